qr_gs_sched: RTL and testbench

Sequencing controller for the Gram-Schmidt QR datapath. On a single `go` pulse it walks columns j = 0..N-1 and previous vectors i = 0..j-1. For each step it starts the dot-product, projection and normalisation units in order, waits on each unit's done handshake and issues the write strobes for R and Q storage. It sits between the top-level host interface and the per-column datapath units, which are streaming units with a held `stop`/done output.

---
 rtl/qr_pkg.sv | 23 ++
 rtl/qr_timeout_cnt.sv | 28 ++
 rtl/qr_gs_sched.sv | 159 +++++++++++++++
 tb/tb_qr_gs_sched.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qr_pkg.sv
// Shared types and defaults for the Gram-Schmidt QR sequencer and its datapath.
package qr_pkg;

  localparam int QR_N       = 3;
  localparam int QR_TIMEOUT = 255;
  localparam int QR_W       = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DOT_RUN,
    ST_R_WR,
    ST_PROJ_RUN,
    ST_NORM_RUN,
    ST_QR_WR,
    ST_FIN,
    ST_ERR
  } qr_state_t;

  function automatic logic is_run_state(input qr_state_t s);
    return (s == ST_DOT_RUN) || (s == ST_PROJ_RUN) || (s == ST_NORM_RUN);
  endfunction

endpackage

// File: rtl/qr_timeout_cnt.sv
// Saturating 8-bit wait counter; expired once the count reaches TIMEOUT.
module qr_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != 8'hFF)) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = (cnt >= LIMIT);

endmodule

// File: rtl/qr_gs_sched.sv
// Gram-Schmidt QR sequencer: walks columns j and previous vectors i, driving
// the dot / projection / normalisation units and the R and Q write strobes.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   IDLE      | waiting for go
//   DOT_RUN   | dot unit running, r_ij = q_i . a_j
//   R_WR      | write r_ij at (i, j)
//   PROJ_RUN  | projection unit running, a_j -= r_ij * q_i
//   NORM_RUN  | normalisation unit running, r_jj and q_j
//   QR_WR     | write r_jj at (j, j) and q_j at j
//   FIN       | one-cycle done pulse
//   ERR       | a unit timed out; sticky until the next go
module qr_gs_sched
  import qr_pkg::*;
#(
  parameter int N       = QR_N,
  parameter int TIMEOUT = QR_TIMEOUT,
  localparam int IW     = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [IW-1:0] col_idx,
  output logic [IW-1:0] q_idx,
  output logic          dot_start,
  output logic          proj_start,
  output logic          norm_start,
  input  logic          dot_done,
  input  logic          proj_done,
  input  logic          norm_done,
  output logic          dot_clr,
  output logic          proj_clr,
  output logic          norm_clr,
  output logic          r_wr_en,
  output logic [IW-1:0] r_wr_row,
  output logic [IW-1:0] r_wr_col,
  output logic          q_wr_en,
  output logic [IW-1:0] q_wr_addr
);

  localparam logic [IW-1:0] J_LAST = IW'(N - 1);

  qr_state_t     state, state_nxt;
  logic [IW-1:0] j_q, i_q, j_nxt, i_nxt;
  logic          awaited_done, expired, to_clr, to_en;
  logic          more_prev;
  logic          dot_clr_q, proj_clr_q, norm_clr_q;

  assign more_prev = (({1'b0, i_q} + (IW+1)'(1)) < {1'b0, j_q});

  always_comb begin
    awaited_done = 1'b0;
    case (state)
      ST_DOT_RUN:  awaited_done = dot_done;
      ST_PROJ_RUN: awaited_done = proj_done;
      ST_NORM_RUN: awaited_done = norm_done;
      default:     awaited_done = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    j_nxt     = j_q;
    i_nxt     = i_q;
    case (state)
      ST_IDLE, ST_ERR: begin
        if (go) begin
          state_nxt = ST_NORM_RUN;
          j_nxt     = '0;
          i_nxt     = '0;
        end
      end
      ST_DOT_RUN: begin
        if (dot_done)     state_nxt = ST_R_WR;
        else if (expired) state_nxt = ST_ERR;
      end
      ST_R_WR: state_nxt = ST_PROJ_RUN;
      ST_PROJ_RUN: begin
        if (proj_done) begin
          if (more_prev) begin
            i_nxt     = i_q + IW'(1);
            state_nxt = ST_DOT_RUN;
          end else begin
            state_nxt = ST_NORM_RUN;
          end
        end else if (expired) begin
          state_nxt = ST_ERR;
        end
      end
      ST_NORM_RUN: begin
        if (norm_done)    state_nxt = ST_QR_WR;
        else if (expired) state_nxt = ST_ERR;
      end
      ST_QR_WR: begin
        if (j_q == J_LAST) begin
          state_nxt = ST_FIN;
        end else begin
          j_nxt     = j_q + IW'(1);
          i_nxt     = '0;
          state_nxt = ST_DOT_RUN;
        end
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Counter restarts on every state change so each RUN state gets a full budget.
  assign to_clr = (state_nxt != state) || !is_run_state(state);
  assign to_en  = is_run_state(state) && !awaited_done;

  qr_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (to_clr),
    .en      (to_en),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      j_q        <= '0;
      i_q        <= '0;
      dot_clr_q  <= 1'b0;
      proj_clr_q <= 1'b0;
      norm_clr_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      j_q        <= j_nxt;
      i_q        <= i_nxt;
      dot_clr_q  <= (state == ST_DOT_RUN)  && dot_done;
      proj_clr_q <= (state == ST_PROJ_RUN) && proj_done;
      norm_clr_q <= (state == ST_NORM_RUN) && norm_done;
    end
  end

  assign busy       = (state != ST_IDLE) && (state != ST_ERR);
  assign done       = (state == ST_FIN);
  assign err        = (state == ST_ERR);
  assign col_idx    = j_q;
  assign q_idx      = i_q;
  assign dot_start  = (state == ST_DOT_RUN);
  assign proj_start = (state == ST_PROJ_RUN);
  assign norm_start = (state == ST_NORM_RUN);
  assign dot_clr    = dot_clr_q;
  assign proj_clr   = proj_clr_q;
  assign norm_clr   = norm_clr_q;
  assign r_wr_en    = (state == ST_R_WR) || (state == ST_QR_WR);
  assign r_wr_row   = (state == ST_R_WR) ? i_q : ((state == ST_QR_WR) ? j_q : '0);
  assign r_wr_col   = r_wr_en ? j_q : '0;
  assign q_wr_en    = (state == ST_QR_WR);
  assign q_wr_addr  = q_wr_en ? j_q : '0;

endmodule

// File: tb/tb_qr_gs_sched.sv
// Self-checking bench for qr_gs_sched: unit models with random latency, a
// behavioural schedule model, and per-cycle handshake checking.
module tb_qr_gs_sched;

  localparam int N       = 3;
  localparam int TIMEOUT = 255;
  localparam int IW      = $clog2(N);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          go = 1'b0;
  logic          busy, done, err;
  logic [IW-1:0] col_idx, q_idx, r_wr_row, r_wr_col, q_wr_addr;
  logic          dot_start, proj_start, norm_start;
  logic          dot_clr, proj_clr, norm_clr;
  logic          r_wr_en, q_wr_en;

  logic [2:0] done_m = 3'b000;
  logic [2:0] rnd_in = 3'b000;
  logic       stray_p = 1'b0;
  logic [2:0] unit_done, st, clr;
  logic [5*IW+10:0] outs;

  assign unit_done = done_m | rnd_in | {1'b0, stray_p, 1'b0};
  assign st  = {norm_start, proj_start, dot_start};
  assign clr = {norm_clr, proj_clr, dot_clr};
  assign outs = {busy, done, err, col_idx, q_idx, dot_start, proj_start, norm_start,
                 dot_clr, proj_clr, norm_clr, r_wr_en, r_wr_row, r_wr_col, q_wr_en, q_wr_addr};

  qr_gs_sched #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .col_idx    (col_idx),
    .q_idx      (q_idx),
    .dot_start  (dot_start),
    .proj_start (proj_start),
    .norm_start (norm_start),
    .dot_done   (unit_done[0]),
    .proj_done  (unit_done[1]),
    .norm_done  (unit_done[2]),
    .dot_clr    (dot_clr),
    .proj_clr   (proj_clr),
    .norm_clr   (norm_clr),
    .r_wr_en    (r_wr_en),
    .r_wr_row   (r_wr_row),
    .r_wr_col   (r_wr_col),
    .q_wr_en    (q_wr_en),
    .q_wr_addr  (q_wr_addr)
  );

  initial forever #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int fixed_d = 0;
  bit hang_dot = 0, stray_en = 0, extra_go = 0;
  int sum_d = 0;
  int ucnt[3] = '{0, 0, 0};
  int utgt[3] = '{1, 1, 1};

  // Unit models: done rises D cycles into the start level and holds until clr.
  always @(posedge clk) begin
    #1;
    for (int u = 0; u < 3; u++) begin
      if (!reset) begin
        done_m[u] = 1'b0;
        ucnt[u]   = 0;
      end else if (clr[u]) begin
        done_m[u] = 1'b0;
        ucnt[u]   = 0;
      end else if (st[u] && !(u == 0 && hang_dot)) begin
        ucnt[u]++;
        if (ucnt[u] == 1) begin
          utgt[u] = (fixed_d > 0) ? fixed_d : int'($urandom_range(1, 4));
          sum_d  += utgt[u];
        end
        if (ucnt[u] >= utgt[u]) done_m[u] = 1'b1;
      end else if (!st[u]) begin
        ucnt[u] = 0;
      end
    end
    stray_p = stray_en && dot_start && ($urandom_range(0, 2) == 0);
  end

  string uname[3] = '{"D", "P", "N"};
  string ops_s = "", rw_s = "", qw_s = "";
  int    busy_cyc = 0, done_cnt = 0, done_at = -1, clr_cnt = 0, hs_bad = 0;
  logic [2:0] p_st = 3'b000, p_dn = 3'b000;

  always @(negedge clk) begin
    if (reset) begin
      for (int u = 0; u < 3; u++) begin
        if (st[u] && !p_st[u]) ops_s = {ops_s, uname[u]};
        if (clr[u] !== (p_st[u] & p_dn[u])) hs_bad++;
        if (clr[u] && st[u]) hs_bad++;
        if (clr[u]) clr_cnt++;
      end
      if (r_wr_en) rw_s = {rw_s, $sformatf("(%0d,%0d)", r_wr_row, r_wr_col)};
      if (q_wr_en) qw_s = {qw_s, $sformatf("%0d ", q_wr_addr)};
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++;
        done_at = busy_cyc;
      end
      p_st = st;
      p_dn = unit_done;
    end else begin
      p_st = 3'b000;
      p_dn = 3'b000;
    end
  end

  string exp_ops, exp_rw, exp_qw;

  task automatic build_model();
    exp_ops = ""; exp_rw = ""; exp_qw = "";
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < j; i++) begin
        exp_ops = {exp_ops, "DP"};
        exp_rw  = {exp_rw, $sformatf("(%0d,%0d)", i, j)};
      end
      exp_ops = {exp_ops, "N"};
      exp_rw  = {exp_rw, $sformatf("(%0d,%0d)", j, j)};
      exp_qw  = {exp_qw, $sformatf("%0d ", j)};
    end
  endtask

  task automatic do_run(input int budget, output bit ok);
    ops_s = ""; rw_s = ""; qw_s = "";
    busy_cyc = 0; done_cnt = 0; done_at = -1; clr_cnt = 0; sum_d = 0;
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      go = extra_go && busy && ($urandom_range(0, 3) == 0);
      if (done_cnt > 0) begin
        ok = 1;
        break;
      end
    end
    go = 1'b0;
  endtask

  task automatic test_reset();
    bit fin;
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      go = 1'($urandom);
      rnd_in = 3'($urandom);
      @(negedge clk);
      vectors++;
      if (outs !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs: got %h, expected 0", outs);
      end
    end
    go = 1'b0; rnd_in = 3'b000;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1 go = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_before_go: got %b, expected 0", busy);
    end
    @(posedge clk); #1 go = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, norm_start} !== 2'b11) begin
      miscompares++;
      $display("FAIL busy_after_go: got busy/norm_start %b, expected 11", {busy, norm_start});
    end
    fin = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!busy) begin
        fin = 1;
        break;
      end
    end
    vectors++;
    if (!fin) begin
      miscompares++;
      $display("FAIL reset_run_timeout: busy still %b, expected 0", busy);
    end
  endtask

  task automatic test_normal();
    bit ok;
    fixed_d = 2; hs_bad = 0;
    do_run(200, ok);
    build_model();
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL normal_done_seen: got 0, expected 1"); end
    vectors++;
    if (ops_s != exp_ops) begin miscompares++; $display("FAIL normal_unit_order: got %s, expected %s", ops_s, exp_ops); end
    vectors++;
    if (rw_s != exp_rw) begin miscompares++; $display("FAIL normal_r_writes: got %s, expected %s", rw_s, exp_rw); end
    vectors++;
    if (qw_s != exp_qw) begin miscompares++; $display("FAIL normal_q_writes: got %s, expected %s", qw_s, exp_qw); end
    vectors++;
    if (busy_cyc !== 25) begin miscompares++; $display("FAIL normal_busy_cycles: got %0d, expected 25", busy_cyc); end
    vectors++;
    if (done_cnt !== 1 || done_at !== busy_cyc) begin
      miscompares++;
      $display("FAIL normal_done_pulse: got count %0d at %0d, expected 1 at %0d", done_cnt, done_at, busy_cyc);
    end
    vectors++;
    if (hs_bad !== 0) begin miscompares++; $display("FAIL normal_handshake: got %0d bad cycles, expected 0", hs_bad); end
    fixed_d = 0;
  endtask

  task automatic test_handshake();
    bit ok;
    stray_en = 1; fixed_d = 0;
    build_model();
    for (int r = 0; r < 3; r++) begin
      hs_bad = 0;
      do_run(300, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL hs_done_seen run %0d: got 0, expected 1", r); end
      vectors++;
      if (ops_s != exp_ops) begin miscompares++; $display("FAIL hs_unit_order run %0d: got %s, expected %s", r, ops_s, exp_ops); end
      vectors++;
      if (clr_cnt !== N * (N - 1) + N) begin
        miscompares++;
        $display("FAIL hs_clr_count run %0d: got %0d, expected %0d", r, clr_cnt, N * (N - 1) + N);
      end
      vectors++;
      if (hs_bad !== 0) begin miscompares++; $display("FAIL hs_clr_timing run %0d: got %0d bad cycles, expected 0", r, hs_bad); end
      vectors++;
      if (busy_cyc !== sum_d + N * (N - 1) / 2 + N + 1) begin
        miscompares++;
        $display("FAIL hs_busy_cycles run %0d: got %0d, expected %0d", r, busy_cyc, sum_d + N * (N - 1) / 2 + N + 1);
      end
    end
    stray_en = 0;
  endtask

  task automatic test_timeout();
    int k;
    bit ok;
    hang_dot = 1; hs_bad = 0; k = 0;
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (dot_start) k++;
      else if (k > 0) break;
    end
    vectors++;
    if (k !== TIMEOUT + 1) begin miscompares++; $display("FAIL timeout_cycles: got %0d, expected %0d", k, TIMEOUT + 1); end
    vectors++;
    if ({err, busy} !== 2'b10) begin miscompares++; $display("FAIL timeout_err_busy: got %b, expected 10", {err, busy}); end
    repeat (3) @(negedge clk);
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("FAIL timeout_err_sticky: got %b, expected 1", err); end
    vectors++;
    if (hs_bad !== 0 || clr !== 3'b000) begin
      miscompares++;
      $display("FAIL timeout_no_clr: got %0d bad cycles clr %b, expected 0 and 000", hs_bad, clr);
    end
    hang_dot = 0;
    do_run(300, ok);
    build_model();
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL timeout_rerun_done: got 0, expected 1"); end
    vectors++;
    if (ops_s != exp_ops || rw_s != exp_rw) begin
      miscompares++;
      $display("FAIL timeout_rerun_sched: got %s %s, expected %s %s", ops_s, rw_s, exp_ops, exp_rw);
    end
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL timeout_err_cleared: got %b, expected 0", err); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    extra_go = 1; fixed_d = 0;
    build_model();
    for (int r = 0; r < 2; r++) begin
      do_run(300, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL b2b_done_seen run %0d: got 0, expected 1", r); end
      vectors++;
      if (rw_s != exp_rw || qw_s != exp_qw) begin
        miscompares++;
        $display("FAIL b2b_writes run %0d: got %s / %s, expected %s / %s", r, rw_s, qw_s, exp_rw, exp_qw);
      end
      vectors++;
      if (done_cnt !== 1 || busy_cyc !== sum_d + N * (N - 1) / 2 + N + 1) begin
        miscompares++;
        $display("FAIL b2b_busy run %0d: got done %0d busy %0d, expected 1 and %0d", r, done_cnt, busy_cyc,
                 sum_d + N * (N - 1) / 2 + N + 1);
      end
    end
    extra_go = 0;
  endtask

  task automatic test_abort();
    bit hit, ok;
    fixed_d = 3; hit = 0;
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (proj_start && col_idx == IW'(2)) begin
        hit = 1;
        break;
      end
    end
    vectors++;
    if (!hit) begin miscompares++; $display("FAIL abort_reach_proj: got 0, expected 1"); end
    #1 reset = 1'b0;
    #1;
    vectors++;
    if (outs !== '0) begin miscompares++; $display("FAIL abort_immediate: got %h, expected 0", outs); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++;
      if (outs !== '0) begin miscompares++; $display("FAIL abort_held %0d: got %h, expected 0", c, outs); end
    end
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++;
      if (outs !== '0) begin miscompares++; $display("FAIL abort_idle %0d: got %h, expected 0", c, outs); end
    end
    fixed_d = 0;
    do_run(300, ok);
    build_model();
    vectors++;
    if (!ok || ops_s != exp_ops || qw_s != exp_qw) begin
      miscompares++;
      $display("FAIL abort_rerun: got ok %0d %s %s, expected 1 %s %s", ok, ops_s, qw_s, exp_ops, exp_qw);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_normal();
    test_handshake();
    test_timeout();
    test_back_to_back();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
